// File: rtl/demux_pkg.sv
// Shared constants for the registered demux tree (1x2 leaf, 1x4 level).
// DEMUX_1X2_HOLD_EN: deselected output holds its value instead of clearing.
package demux_pkg;

   localparam logic SEL_OUT1 = 1'b0;
   localparam logic SEL_OUT2 = 1'b1;

   localparam int DEMUX_WIDTH = 1;

`ifdef DEMUX_1X2_HOLD_EN
   localparam bit HOLD_EN = 1'b1;
`else
   localparam bit HOLD_EN = 1'b0;
`endif

endpackage

// File: rtl/demux_1x2_sync_if.sv
// Routing bundle for the registered 1x2 demux.
// Master drives Sel/E; slave returns Out1/Out2.
interface demux_1x2_sync_if
   import demux_pkg::*;
#(
   parameter int WIDTH = DEMUX_WIDTH
);

   logic             Sel;
   logic [WIDTH-1:0] E;
   logic [WIDTH-1:0] Out1;
   logic [WIDTH-1:0] Out2;

   modport master (
      output Sel,
      output E,
      input  Out1,
      input  Out2
   );

   modport slave (
      input  Sel,
      input  E,
      output Out1,
      output Out2
   );

endinterface

// File: rtl/demux_1x2_cell.sv
// Combinational next-state routing for one 1x2 demux stage.
// DEMUX_1X2_HOLD_EN: deselected output keeps its current value.
module demux_1x2_cell
   import demux_pkg::*;
#(
   parameter int WIDTH = DEMUX_WIDTH
) (
   input  logic             sel,
   input  logic [WIDTH-1:0] e,
   input  logic [WIDTH-1:0] out1_q,
   input  logic [WIDTH-1:0] out2_q,
   output logic [WIDTH-1:0] out1_d,
   output logic [WIDTH-1:0] out2_d
);

   always_comb begin
      // Deselected side: hold or clear
      out1_d = HOLD_EN ? out1_q : '0;
      out2_d = HOLD_EN ? out2_q : '0;
      unique case (1'b1)
         (sel == SEL_OUT1): out1_d = e;
         (sel == SEL_OUT2): out2_d = e;
         default: ;
      endcase
   end

endmodule

// File: rtl/demux_1x2_sync.sv
// Registered 1-to-2 demultiplexer: output registers plus sync reset.
// DEMUX_1X2_HOLD_EN: deselected output holds (see demux_1x2_cell).
module demux_1x2_sync
   import demux_pkg::*;
#(
   parameter int WIDTH = DEMUX_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   demux_1x2_sync_if.slave  bus
);

   logic [WIDTH-1:0] out1_d;
   logic [WIDTH-1:0] out2_d;

   demux_1x2_cell #(
      .WIDTH (WIDTH)
   ) u_cell (
      .sel    (bus.Sel),
      .e      (bus.E),
      .out1_q (bus.Out1),
      .out2_q (bus.Out2),
      .out1_d (out1_d),
      .out2_d (out2_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.Out1 <= '0;
         bus.Out2 <= '0;
      end else begin
         bus.Out1 <= out1_d;
         bus.Out2 <= out2_d;
      end
   end

endmodule

// File: tb/tb_demux_1x2_sync.sv
// Bench for demux_1x2_sync at WIDTH=8: directed vectors plus a
// per-cycle model compare; honours DEMUX_1X2_HOLD_EN.
module tb_demux_1x2_sync;

   localparam int W = 8;
`ifdef DEMUX_1X2_HOLD_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;

   demux_1x2_sync_if #(.WIDTH(W)) bus ();

   demux_1x2_sync #(
      .WIDTH (W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   // Model: outputs indexed by destination, updated from the inputs seen at each edge
   logic [W-1:0] m_out [2];
   bit           m_valid = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_out[0] = '0;
         m_out[1] = '0;
      end else begin
         m_out[bus.Sel] = bus.E;
         if (!HOLD) m_out[!bus.Sel] = '0;
      end
      m_valid = 1'b1;
   end

   task automatic check(input string name, input logic [W-1:0] act,
                        input logic [W-1:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h, required %h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         check("model_out1", bus.Out1, m_out[0]);
         check("model_out2", bus.Out2, m_out[1]);
         if (!HOLD) check("onehot", bus.Out1 & bus.Out2, '0);
      end
   end

   task automatic cyc(input logic r, input logic s, input logic [W-1:0] e);
      rst     = r;
      bus.Sel = s;
      bus.E   = e;
      @(posedge clk);
      #1;
   endtask

   logic [W-1:0] h1, hA5;

   initial begin
      h1  = HOLD ? 8'h01 : 8'h00;
      hA5 = HOLD ? 8'hA5 : 8'h00;
      rst = 1'b1;
      bus.Sel = 1'b1;
      bus.E = 8'h01;
      #2;

      cyc(1, 1, 8'h01);
      check("rst0_out1", bus.Out1, 8'h00);
      check("rst0_out2", bus.Out2, 8'h00);
      cyc(1, 1, 8'h01);
      check("rst1_out1", bus.Out1, 8'h00);
      check("rst1_out2", bus.Out2, 8'h00);

      cyc(0, 0, 8'h01);
      check("sel0_out1", bus.Out1, 8'h01);
      check("sel0_out2", bus.Out2, 8'h00);
      cyc(0, 1, 8'h01);
      check("sel1_out1", bus.Out1, h1);
      check("sel1_out2", bus.Out2, 8'h01);

      cyc(0, 0, 8'h00);
      check("e0s0_out1", bus.Out1, 8'h00);
      check("e0s0_out2", bus.Out2, h1);
      cyc(0, 1, 8'h00);
      check("e0s1_out1", bus.Out1, 8'h00);
      check("e0s1_out2", bus.Out2, 8'h00);

      cyc(0, 1, 8'hA5);
      check("a5s1_out1", bus.Out1, 8'h00);
      check("a5s1_out2", bus.Out2, 8'hA5);
      cyc(0, 0, 8'hA5);
      check("a5s0_out1", bus.Out1, 8'hA5);
      check("a5s0_out2", bus.Out2, hA5);

      cyc(0, 1, 8'h01);
      check("pre_rst_out1", bus.Out1, hA5);
      check("pre_rst_out2", bus.Out2, 8'h01);
      cyc(1, 1, 8'h01);
      check("mid_rst_out1", bus.Out1, 8'h00);
      check("mid_rst_out2", bus.Out2, 8'h00);
      cyc(0, 1, 8'h01);
      check("post_rst_out1", bus.Out1, 8'h00);
      check("post_rst_out2", bus.Out2, 8'h01);

      cyc(0, 0, 8'h01);
      check("hold_a_out1", bus.Out1, 8'h01);
      check("hold_a_out2", bus.Out2, h1);
      cyc(0, 1, 8'h00);
      check("hold_b_out1", bus.Out1, h1);
      check("hold_b_out2", bus.Out2, 8'h00);

      for (int i = 0; i < 60; i++) begin
         cyc(($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)));
      end
      cyc(0, 0, 8'h00);
      @(negedge clk);
      #1;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
